// File: rtl/bus_responder_if.sv
// Multiplexed 8-bit address/data bus between an initiator (master) and the
// memory-window responder (slave).
interface bus_responder_if;
    logic [7:0]  inAD;
    logic [11:0] A;
    logic        ALE;
    logic        RD_n;
    logic        WR_n;
    logic        IOM;
    logic [7:0]  outAD;
    logic [7:0]  enAD;
    logic        READY;
    logic        hit;

    modport master (
        output inAD, A, ALE, RD_n, WR_n, IOM,
        input  outAD, enAD, READY, hit
    );

    modport slave (
        input  inAD, A, ALE, RD_n, WR_n, IOM,
        output outAD, enAD, READY, hit
    );
endinterface

// File: rtl/bus_responder.sv
// Byte-wide RAM window responder on a multiplexed 8-bit bus with wait states.
// Define BUS_RESPONDER_IO_EN to add four I/O registers at 16'h00F0..16'h00F3.
module bus_responder #(
    parameter logic [19:0] BASE        = 20'h00000,
    parameter int          SIZE_LOG2   = 10,
    parameter int          WAIT_STATES = 2
) (
    input logic            CLKx4,
    input logic            RESET_n,
    bus_responder_if.slave bus
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_WAIT,
        WR_CAPTURE
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [19:0]    addr_q;
    logic           iom_q;
    logic           rd_q;
    logic           wr_q;
    logic [7:0]     hold;
    logic           ready_q;
    logic [7:0]     en_q;
    logic [7:0]     out_q;

    logic [7:0]     mem [0:(1 << SIZE_LOG2) - 1];

    // Decode is done on the latched address, so hit only moves after an ALE edge.
    logic [20:0]          diff;
    logic                 mem_hit;
    logic                 io_sel;
    logic [SIZE_LOG2-1:0] offset;
    logic [7:0]           rd_data;
    logic                 hit;
    logic                 rd_fall;
    logic                 wr_fall;
    logic                 commit;

    assign diff    = {1'b0, addr_q} - {1'b0, BASE};
    assign mem_hit = iom_q && ((diff >> SIZE_LOG2) == 21'd0);
    assign offset  = diff[SIZE_LOG2-1:0];
    assign hit     = mem_hit || io_sel;
    assign rd_fall = rd_q && !bus.RD_n;
    assign wr_fall = wr_q && !bus.WR_n;
    assign commit  = (state == WR_CAPTURE) && bus.WR_n && !bus.ALE;

`ifdef BUS_RESPONDER_IO_EN
    logic [7:0] io_reg [0:3];

    assign io_sel  = !iom_q && (addr_q[15:2] == 14'h003C);
    assign rd_data = io_sel ? io_reg[addr_q[1:0]] : mem[offset];

    always_ff @(posedge CLKx4 or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int i = 0; i < 4; i++) io_reg[i] <= 8'h00;
        end else if (commit && io_sel) begin
            io_reg[addr_q[1:0]] <= hold;
        end
    end
`else
    assign io_sel  = 1'b0;
    assign rd_data = mem[offset];
`endif

    // NOTE: the RAM has no reset; contents survive RESET_n by design, and a
    // reset-free block lets it map onto plain block RAM.
    always_ff @(posedge CLKx4) begin
        if (commit && !io_sel) mem[offset] <= hold;
    end

    // NOTE: every sequential assignment is non-blocking so all registers see
    // pre-edge values, independent of statement order.
    always_ff @(posedge CLKx4 or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 20'h00000;
            iom_q   <= 1'b0;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            hold    <= 8'h00;
            ready_q <= 1'b1;
            en_q    <= 8'h00;
            out_q   <= 8'h00;
        end else begin
            rd_q <= bus.RD_n;
            wr_q <= bus.WR_n;
            if (bus.ALE) begin
                addr_q  <= {bus.A, bus.inAD};
                iom_q   <= bus.IOM;
                // A new address phase kills whatever access was in flight.
                state   <= IDLE;
                cnt     <= 4'd0;
                ready_q <= 1'b1;
                en_q    <= 8'h00;
            end else begin
                case (state)
                    IDLE: begin
                        if (hit && rd_fall) begin
                            if (WS == 4'd0) begin
                                state <= RD_DRIVE;
                                out_q <= rd_data;
                                en_q  <= 8'hFF;
                            end else begin
                                state   <= RD_WAIT;
                                cnt     <= WS;
                                ready_q <= 1'b0;
                            end
                        end else if (hit && wr_fall) begin
                            if (WS == 4'd0) begin
                                state <= WR_CAPTURE;
                            end else begin
                                state   <= WR_WAIT;
                                cnt     <= WS;
                                ready_q <= 1'b0;
                            end
                        end
                    end
                    RD_WAIT: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= RD_DRIVE;
                            ready_q <= 1'b1;
                            out_q   <= rd_data;
                            en_q    <= 8'hFF;
                        end
                    end
                    RD_DRIVE: begin
                        // rd_q holds the previous sample: release one edge after RD_n rose.
                        if (rd_q) begin
                            state <= IDLE;
                            en_q  <= 8'h00;
                        end
                    end
                    WR_WAIT: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= WR_CAPTURE;
                            ready_q <= 1'b1;
                        end
                    end
                    WR_CAPTURE: begin
                        if (bus.WR_n) state <= IDLE;
                        else          hold  <= bus.inAD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.outAD = out_q;
    assign bus.enAD  = en_q;
    assign bus.READY = ready_q;
    assign bus.hit   = hit;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench: dut0 uses the default two wait states, dut1 has none; both
// share the initiator strobes so they hold identical memory contents.
module tb_bus_responder;

`ifdef BUS_RESPONDER_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  ad;
    logic [11:0] a_hi;
    logic        ale, rd_n, wr_n, iom;

    int compared   = 0;
    int mismatched = 0;
    int ws0_low    = 0;

    bus_responder_if b0 ();
    bus_responder_if b1 ();

    assign b0.inAD = ad;   assign b1.inAD = ad;
    assign b0.A    = a_hi; assign b1.A    = a_hi;
    assign b0.ALE  = ale;  assign b1.ALE  = ale;
    assign b0.RD_n = rd_n; assign b1.RD_n = rd_n;
    assign b0.WR_n = wr_n; assign b1.WR_n = wr_n;
    assign b0.IOM  = iom;  assign b1.IOM  = iom;

    bus_responder #(.BASE(20'h00000), .SIZE_LOG2(10), .WAIT_STATES(2)) dut0 (
        .CLKx4(clk), .RESET_n(rst_n), .bus(b0.slave)
    );
    bus_responder #(.BASE(20'h00000), .SIZE_LOG2(10), .WAIT_STATES(0)) dut1 (
        .CLKx4(clk), .RESET_n(rst_n), .bus(b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (b1.READY !== 1'b1) ws0_low++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic io_m, input logic [19:0] addr);
        a_hi = addr[19:8];
        ad   = addr[7:0];
        iom  = io_m;
        ale  = 1'b1;
        tick();
        ale  = 1'b0;
    endtask

    task automatic wait_ready(output int lows);
        bit done = 1'b0;
        lows = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (b0.READY === 1'b1) done = 1'b1;
            else lows++;
        end
    endtask

    task automatic do_write(input logic io_m, input logic [19:0] addr, input logic [7:0] data,
                            output logic h, output int lows);
        addr_phase(io_m, addr);
        h    = b0.hit;
        ad   = data;
        wr_n = 1'b0;
        wait_ready(lows);
        tick();
        wr_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic do_read(input logic io_m, input logic [19:0] addr, output logic h,
                           output logic [7:0] d, output logic [7:0] en, output int lows,
                           output logic [7:0] en_after);
        addr_phase(io_m, addr);
        h    = b0.hit;
        rd_n = 1'b0;
        wait_ready(lows);
        d    = b0.outAD;
        en   = b0.enAD;
        rd_n = 1'b1;
        tick();
        tick();
        en_after = b0.enAD;
    endtask

    initial begin
        logic       h;
        logic [7:0] d, en, en_after;
        int         lows;

        rst_n = 1'b0; ad = 8'h00; a_hi = 12'h000;
        ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; iom = 1'b0;
        repeat (3) tick();
        check("rst_ready", b0.READY, 1'b1);
        check("rst_enad",  b0.enAD,  8'h00);
        check("rst_outad", b0.outAD, 8'h00);
        check("rst_hit",   b0.hit,   1'b0);
        rst_n = 1'b1;
        tick();

        // Write then read back with two wait states.
        do_write(1'b1, 20'h00010, 8'h5A, h, lows);
        check("wr10_hit",  h,    1'b1);
        check("wr10_lows", lows, 2);
        do_read(1'b1, 20'h00010, h, d, en, lows, en_after);
        check("rd10_hit",      h,        1'b1);
        check("rd10_lows",     lows,     2);
        check("rd10_data",     d,        8'h5A);
        check("rd10_enad",     en,       8'hFF);
        check("rd10_released", en_after, 8'h00);

        // First address past the window is a miss; no wrap-around aliasing.
        do_read(1'b1, 20'h00400, h, d, en, lows, en_after);
        check("rd400_hit",  h,    1'b0);
        check("rd400_lows", lows, 0);
        check("rd400_enad", en,   8'h00);
        do_write(1'b1, 20'h00410, 8'h99, h, lows);
        check("wr410_hit",  h,    1'b0);
        check("wr410_lows", lows, 0);
        do_read(1'b1, 20'h00010, h, d, en, lows, en_after);
        check("rd10_after_miss", d, 8'h5A);

        // ALE during the write wait aborts the access.
        do_write(1'b1, 20'h00020, 8'hA5, h, lows);
        addr_phase(1'b1, 20'h00020);
        ad   = 8'hC3;
        wr_n = 1'b0;
        tick();
        check("abort_ready_low", b0.READY, 1'b0);
        ale  = 1'b1;
        ad   = 8'h20;
        tick();
        check("abort_ready", b0.READY, 1'b1);
        check("abort_enad",  b0.enAD,  8'h00);
        ale  = 1'b0;
        ad   = 8'hC3;
        tick();
        tick();
        check("abort_stays_idle", b0.READY, 1'b1);
        wr_n = 1'b1;
        tick();
        tick();
        do_read(1'b1, 20'h00020, h, d, en, lows, en_after);
        check("abort_rd_lows", lows, 2);
        check("abort_rd_data", d,    8'hA5);

        // I/O register at 16'h00F2; upper address nibble is ignored.
        do_write(1'b0, 20'h300F2, 8'h81, h, lows);
        check("io_wr_hit",  h,    IO_EN);
        check("io_wr_lows", lows, IO_EN ? 2 : 0);
        do_read(1'b0, 20'h000F2, h, d, en, lows, en_after);
        check("io_rd_hit",  h,      IO_EN);
        check("io_rd_enad", en,     IO_EN ? 8'hFF : 8'h00);
        check("io_rd_data", d & en, IO_EN ? 8'h81 : 8'h00);

        // Window edges, then back-to-back reads on the zero-wait responder.
        do_write(1'b1, 20'h00000, 8'h11, h, lows);
        do_write(1'b1, 20'h003FF, 8'hEE, h, lows);
        check("wr3ff_hit", h, 1'b1);
        do_read(1'b1, 20'h003FF, h, d, en, lows, en_after);
        check("rd3ff_data", d, 8'hEE);
        addr_phase(1'b1, 20'h00000);
        rd_n = 1'b0;
        tick();
        check("ws0_rd0_data", b1.outAD, 8'h11);
        check("ws0_rd0_enad", b1.enAD,  8'hFF);
        rd_n = 1'b1;
        tick();
        tick();
        check("ws0_rd0_released", b1.enAD, 8'h00);
        addr_phase(1'b1, 20'h003FF);
        rd_n = 1'b0;
        tick();
        check("ws0_rd3ff_data", b1.outAD, 8'hEE);
        check("ws0_rd3ff_enad", b1.enAD,  8'hFF);
        rd_n = 1'b1;
        repeat (5) tick();

        // Reset in the middle of a driven read.
        do_write(1'b1, 20'h00035, 8'h77, h, lows);
        addr_phase(1'b1, 20'h00035);
        rd_n = 1'b0;
        wait_ready(lows);
        check("pre_rst_enad", b0.enAD, 8'hFF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_enad",  b0.enAD,  8'h00);
        check("mid_rst_ready", b0.READY, 1'b1);
        check("mid_rst_outad", b0.outAD, 8'h00);
        check("mid_rst_hit",   b0.hit,   1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        rd_n  = 1'b1;
        tick();
        tick();
        do_read(1'b1, 20'h00035, h, d, en, lows, en_after);
        check("post_rst_data", d,    8'h77);
        check("post_rst_lows", lows, 2);
        do_read(1'b0, 20'h000F2, h, d, en, lows, en_after);
        check("post_rst_io_enad", en,     IO_EN ? 8'hFF : 8'h00);
        check("post_rst_io_data", d & en, 8'h00);

        check("ws0_ready_never_low", ws0_low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
